// File: rtl/handshake_timeout_monitor.sv
// handshake_timeout_monitor: passive per-channel valid/ready checker flagging timeouts and early
// valid drops, with a saturating error counter and per-channel worst-case latency.
module handshake_timeout_monitor #(
   parameter int NUM_CH       = 4,
   parameter int MAX_WAIT     = 5,
   parameter int CNT_W        = 16,
   parameter int CHECK_STABLE = 1,
   parameter int LAT_W        = $clog2(MAX_WAIT + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [NUM_CH-1:0]       valid,
   input  logic [NUM_CH-1:0]       ready,
   input  logic                    clr_err,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       timeout_err,
   output logic [NUM_CH-1:0]       drop_err,
   output logic [CNT_W-1:0]        err_count,
   output logic [NUM_CH*LAT_W-1:0] max_lat
);
   localparam int PC_W  = $clog2(NUM_CH + 1);
   localparam int SUM_W = CNT_W + PC_W;
   typedef enum logic [1:0] {IDLE, WAIT, TOUT} state_t;
   state_t                  state_q [NUM_CH];
   state_t                  state_d [NUM_CH];
   logic [LAT_W-1:0]        wcnt_q  [NUM_CH];
   logic [LAT_W-1:0]        wcnt_d  [NUM_CH];
   logic [LAT_W-1:0]        lat     [NUM_CH];
   logic [NUM_CH-1:0]       done, tout_ev, drop_ev, err_ev;
   logic [NUM_CH-1:0]       timeout_q, timeout_d, drop_q, drop_d;
   logic [CNT_W-1:0]        err_q, err_d;
   logic [NUM_CH*LAT_W-1:0] max_lat_q, max_lat_d;
   logic [PC_W-1:0]         pc;
   logic [SUM_W-1:0]        sum;
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         wcnt_d[i]  = wcnt_q[i];
         lat[i]     = '0;
         done[i]    = 1'b0;
         tout_ev[i] = 1'b0;
         drop_ev[i] = 1'b0;
         if (!en) state_d[i] = IDLE;
         else begin
            case (state_q[i])
               IDLE: if (valid[i]) begin
                  if (ready[i]) done[i] = 1'b1;
                  else if (MAX_WAIT == 1) begin
                     tout_ev[i] = 1'b1;
                     state_d[i] = TOUT;
                  end else begin
                     state_d[i] = WAIT;
                     wcnt_d[i]  = LAT_W'(1);
                  end
               end
               WAIT: if (!valid[i]) begin
                  drop_ev[i] = (CHECK_STABLE != 0);
                  state_d[i] = IDLE;
               end else if (ready[i]) begin
                  done[i]    = 1'b1;
                  lat[i]     = wcnt_q[i];
                  state_d[i] = IDLE;
               end else if (wcnt_q[i] == LAT_W'(MAX_WAIT - 1)) begin
                  tout_ev[i] = 1'b1;
                  state_d[i] = TOUT;
               end else wcnt_d[i] = wcnt_q[i] + LAT_W'(1);
               TOUT: state_d[i] = (!valid[i] || ready[i]) ? IDLE : TOUT;
               default: state_d[i] = IDLE;
            endcase
         end
         busy[i] = (state_q[i] != IDLE);
      end
   end
   // A clear on the same edge as an event drops only the old history; this edge's events survive.
   always_comb begin
      err_ev    = tout_ev | drop_ev;
      timeout_d = (clr_err ? '0 : timeout_q) | tout_ev;
      drop_d    = (clr_err ? '0 : drop_q) | drop_ev;
      max_lat_d = clr_err ? '0 : max_lat_q;
      pc        = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pc = pc + PC_W'(err_ev[i]);
         if (done[i] && lat[i] > max_lat_d[i*LAT_W +: LAT_W]) max_lat_d[i*LAT_W +: LAT_W] = lat[i];
      end
      sum   = SUM_W'(clr_err ? '0 : err_q) + SUM_W'(pc);
      err_d = (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= IDLE;
            wcnt_q[i]  <= '0;
         end
         timeout_q <= '0;
         drop_q    <= '0;
         err_q     <= '0;
         max_lat_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            wcnt_q[i]  <= wcnt_d[i];
         end
         timeout_q <= timeout_d;
         drop_q    <= drop_d;
         err_q     <= err_d;
         max_lat_q <= max_lat_d;
      end
   end
   assign timeout_err = timeout_q;
   assign drop_err    = drop_q;
   assign err_count   = err_q;
   assign max_lat     = max_lat_q;
endmodule

// File: doc/handshake_timeout_monitor.md
Name: handshake_timeout_monitor

Overview:
Synthesisable, parametrised valid/ready handshake checker for NUM_CH independent channels. Every cycle that a channel's valid is high while out of reset, ready must arrive within MAX_WAIT cycles. Timeouts and early valid drops are flagged per channel, and a saturating error counter and per-channel worst-case latency are kept. It sits passively beside interface buses, in both silicon debug logic and benches; it never drives valid or ready.

Parameters:
NUM_CH, 4, number of monitored channels (>=1)
MAX_WAIT, 5, ready must be sampled at offset 0..MAX_WAIT-1 from the valid start edge (>=1)
CNT_W, 16, width of the saturating error counter
CHECK_STABLE, 1, 1 = valid deasserting before ready is an error
LAT_W, $clog2(MAX_WAIT+1), width of each latency field (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  monitor enable; 0 forces all channels idle
valid  in  NUM_CH  per-channel valid
ready  in  NUM_CH  per-channel ready
clr_err  in  1  synchronous clear of sticky flags, counter and latency stats
busy  out  NUM_CH  channel is in WAIT or TOUT
timeout_err  out  NUM_CH  sticky: ready missed the window
drop_err  out  NUM_CH  sticky: valid dropped before ready (only when CHECK_STABLE=1)
err_count  out  CNT_W  total error events, saturating at all-ones
max_lat  out  NUM_CH*LAT_W  per-channel worst observed latency in cycles, channel i at [i*LAT_W +: LAT_W]

Behaviour:
- Reset (async assert, sync release): all FSMs go to IDLE; busy, timeout_err, drop_err, err_count and max_lat are all 0. Reset mid-transaction abandons it silently.
- Offset 0 (E0) is the edge at which valid is first sampled high in IDLE. All outputs are registered and update after the deciding edge.
- Per-channel FSM, states IDLE / WAIT / TOUT, with wait counter wcnt:
  - IDLE, valid&ready: complete with latency 0; stay in IDLE.
  - IDLE, valid&!ready: go to WAIT with wcnt=1.
  - WAIT, ready&valid: complete with latency wcnt; go to IDLE.
  - WAIT, !valid: if CHECK_STABLE=1, raise a drop error. Go to IDLE in either case.
  - WAIT, valid&!ready&wcnt==MAX_WAIT-1: raise a timeout error; go to TOUT.
  - WAIT, otherwise: wcnt+1.
  - TOUT, (valid&ready) | !valid: go to IDLE. No further error and no latency update; a late ready never clears the flag.
- MAX_WAIT=1: IDLE valid&!ready raises a timeout immediately and goes to TOUT.
- On completion, if latency > max_lat[ch], set max_lat[ch] = latency.
- Error event: sets the sticky bit and adds 1 to err_count. Multiple channels erroring on the same edge add their popcount. Saturate at 2^CNT_W-1 with no wrap.
- clr_err zeroes flags, err_count and max_lat. It does not change FSM state.
- clr_err coinciding with a new error or completion: the new event wins. The flag is set, err_count becomes the popcount of this edge's errors, and max_lat holds this edge's latency.
- en=0: FSMs are forced to IDLE, no events are generated, and stats are held.
- ready without valid is ignored.
- Back-to-back transfers: completion in WAIT followed by valid high on the next edge starts a new transaction at its own E0.

Test Plan:
1. Legacy timing (MAX_WAIT=5, ch0): rst released, valid high from E0, ready rises 7 edges later -> timeout_err[0]=1 after E4, err_count=1, busy[0] held until the ready edge, max_lat[0]=0.
2. In-window completion: valid at E0, ready at E4 -> no error, max_lat[0]=4. Repeat with ready at E0 -> max_lat stays 4, busy never set.
3. Drop (CHECK_STABLE=1): ch2 valid high E0-E1, low at E2, ready never arrives -> drop_err[2]=1, err_count=1, FSM back to IDLE. With CHECK_STABLE=0 -> no flag.
4. Simultaneous multi-channel: ch1 and ch3 both time out on the same edge, with clr_err asserted on that edge and err_count=9 -> flags set, err_count=2.
5. Saturation: CNT_W=2, six timeouts -> err_count sticks at 3.
6. Reset mid-op: ch0 in WAIT (wcnt=3), rst pulsed between edges -> all outputs 0 immediately. A new valid after release times out only after a fresh 5-edge window.
